// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, MSB first, WIDTH-cycle latency.
// Optional macro SEQ_DIVIDER_DZ_DETECT_EN adds a one-cycle divide-by-zero early exit with a dz flag.
module seq_divider #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             dz
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    // dvd shifts dividend bits out of the top while quotient bits shift in at the bottom
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem;
    logic [CW-1:0]    cnt;

    logic             accept;
    logic             last;
    logic             q_bit;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] rem_step;
`ifdef SEQ_DIVIDER_DZ_DETECT_EN
    logic             zero_exit;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus one restoring step: shift in the next dividend bit, trial-subtract the divisor
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        shifted    = {rem, dvd[WIDTH-1]};
        q_bit      = (shifted >= {1'b0, dvs});
        rem_step   = q_bit ? WIDTH'(shifted - {1'b0, dvs}) : shifted[WIDTH-1:0];
        last       = (cnt == CW'(WIDTH - 1));
`ifdef SEQ_DIVIDER_DZ_DETECT_EN
        zero_exit  = 1'b0;
`endif
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = CALC;
`ifdef SEQ_DIVIDER_DZ_DETECT_EN
                    if (divisor == '0) begin
                        zero_exit  = 1'b1;
                        state_next = DONE;
                    end
`endif
                end else begin
                    state_next = IDLE;
                end
            end
            CALC: begin
                if (last) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dvd       <= '0;
            dvs       <= '0;
            rem       <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            busy <= (state_next == CALC);
            done <= (state_next == DONE);
            if (accept) begin
                dvd <= dividend;
                dvs <= divisor;
                rem <= '0;
                cnt <= '0;
`ifdef SEQ_DIVIDER_DZ_DETECT_EN
                if (zero_exit) begin
                    quotient  <= '1;
                    remainder <= dividend;
                end
`endif
            end else if (state == CALC) begin
                dvd <= {dvd[WIDTH-2:0], q_bit};
                rem <= rem_step;
                cnt <= cnt + CW'(1);
                if (last) begin
                    quotient  <= {dvd[WIDTH-2:0], q_bit};
                    remainder <= rem_step;
                end
            end
        end
    end

`ifdef SEQ_DIVIDER_DZ_DETECT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dz <= 1'b0;
        end else begin
            dz <= zero_exit;
        end
    end
`else
    assign dz = 1'b0;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: driver pushes expected results, a forked monitor checks each done pulse.
module tb_seq_divider;

    localparam int unsigned W = 4;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         dz;

    typedef struct {
        int q;
        int r;
        int dz;
        int cyc;
        int lat;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   errors;
    int   checks;

    seq_divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .dz        (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer division; divide-by-zero yields all ones and the dividend
    task automatic issue(input int a, input int b);
        exp_t e;
        if (b == 0) begin
            e.q = (1 << W) - 1;
            e.r = a;
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
`ifdef SEQ_DIVIDER_DZ_DETECT_EN
        e.dz  = (b == 0) ? 1 : 0;
        e.lat = (b == 0) ? 0 : int'(W);
`else
        e.dz  = 0;
        e.lat = int'(W);
`endif
        e.cyc = cyc + 1 + e.lat;
        sb.push_back(e);
        start    = 1'b1;
        dividend = W'(a);
        divisor  = W'(b);
    endtask

    // Wait (bounded) at negedges for done; returns the number of busy cycles seen
    task automatic wait_done(output int nbusy);
        int bound;
        nbusy = 0;
        bound = 20;
        while (!done && bound > 0) begin
            if (busy) nbusy++;
            @(negedge clk);
            bound--;
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    // Called at a negedge; returns at the negedge where done is high
    task automatic run_op(input int a, input int b);
        int nbusy;
        int exp_busy;
        exp_busy = int'(W);
`ifdef SEQ_DIVIDER_DZ_DETECT_EN
        if (b == 0) exp_busy = 0;
`endif
        issue(a, b);
        @(negedge clk);
        start = 1'b0;
        wait_done(nbusy);
        chk("busy_cycles", nbusy, exp_busy);
    endtask

    initial begin
        int nbusy;
        errors   = 0;
        checks   = 0;
        reset    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;

        // Monitor: every done pulse must match the oldest expected result, on the expected cycle
        fork
            forever begin
                @(negedge clk);
                if (done) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("quotient", int'(quotient), e.q);
                        chk("remainder", int'(remainder), e.r);
                        chk("dz", int'(dz), e.dz);
                        chk("done_cycle", cyc, e.cyc);
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        chk("rst_quotient", int'(quotient), 0);
        chk("rst_remainder", int'(remainder), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_dz", int'(dz), 0);
        reset = 1'b1;
        #1;
        chk("rel_quotient", int'(quotient), 0);
        chk("rel_busy", int'(busy), 0);

        // First start accepted on the first edge after release
        run_op(13, 3);
        @(negedge clk);
        chk("idle_after_done", int'(done), 0);
        run_op(15, 1);
        run_op(2, 5);
        run_op(9, 0);
        @(negedge clk);

        // Start during CALC is ignored
        issue(13, 3);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start    = 1'b1;
        dividend = 4'd7;
        divisor  = 4'd2;
        @(negedge clk);
        start = 1'b0;
        wait_done(nbusy);
        @(negedge clk);

        // Asynchronous reset mid-CALC discards the operation
        issue(13, 3);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2;
        reset = 1'b0;
        sb.delete();
        #1;
        chk("midrst_quotient", int'(quotient), 0);
        chk("midrst_remainder", int'(remainder), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("no_done_after_rst", int'(done), 0);
        end
        run_op(7, 2);
        @(negedge clk);

        // Start held through done: back-to-back operations
        issue(13, 3);
        wait_done(nbusy);
        issue(14, 4);
        @(negedge clk);
        start = 1'b0;
        chk("hold_quotient", int'(quotient), 4);
        chk("hold_remainder", int'(remainder), 1);
        @(negedge clk);
        wait_done(nbusy);
        @(negedge clk);

        // Randomized operations with random gaps, including back-to-back starts on done
        for (int i = 0; i < 60; i++) begin
            int a;
            int b;
            a = int'($urandom_range(0, (1 << W) - 1));
            b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, (1 << W) - 1));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_op(a, b);
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
